eth_link_supervisor: RTL
========================

// Module: eth_link_supervisor
// PURPOSE
//  Parametrised per-port link supervisor for NUM_PORTS triple-speed Ethernet MAC/PHY channels in the sys_clk domain.
//  Sequences the shared PHY reset after PLL lock, tracks each MAC's reported speed, and debounces speed changes.
//  On each accepted change it holds that port's MAC TX path in reset while the external TX clock mux switches.
//  It replaces fixed two-port combinational clock selection with glitch-rejecting, per-port sequenced switching.
// PARAMETERS
//  NUM_PORTS          2      number of MAC/PHY channels (>=1)
//  DEBOUNCE_CYCLES    1024   consecutive identical samples needed to accept a speed change (>=1)
//  RESET_HOLD         64     cycles mac_tx_reset stays high per switch (>=2)
//  PHY_RST_CYCLES     500000 cycles phy_reset_n held low after PLL lock
//  PHY_SETTLE_CYCLES  50000  cycles after phy_reset_n release before ready
//  CNT_W              8      width of per-port speed-change counter
// PORTS
//  clk              in   1                  sys_clk; all logic on rising edge
//  reset            in   1                  synchronous, active-high
//  pll_locked       in   1                  PLL lock (async; 2-FF synchronised internally)
//  eth_mode         in   NUM_PORTS          per-port MAC eth_mode (1 = GbE), async, 2-FF synced
//  ena_10           in   NUM_PORTS          per-port MAC ena_10 (1 = 10Mb), async, 2-FF synced
//  phy_reset_n      out  1                  shared PHY reset, active-low
//  ready            out  1                  1 while global FSM in RUN
//  tx_clk_sel       out  2*NUM_PORTS        per-port clock select [2p+1:2p]: 00 = 2.5M, 01 = 25M, 10 = 125M
//  mac_tx_reset     out  NUM_PORTS          per-port MAC TX-path reset, active-high
//  speed_change_cnt out  CNT_W*NUM_PORTS    per-port accepted-change count, saturating
// BEHAVIOUR
//  Reset and clocking (already decided): one clock, clk; reset is synchronous and active-high.
//  Reset values: phy_reset_n = 0, ready = 0, tx_clk_sel = 01 on every port, mac_tx_reset = all 1s, speed_change_cnt = 0.
//  Candidate speed code (from synced inputs): eth_mode = 1 -> 10; else ena_10 = 1 -> 00; else 01. Code 11 is never produced.
//  Global FSM:
//   - PHY_RST: phy_reset_n = 0. Counter advances only while synced pll_locked = 1; otherwise it holds at 0.
//     After PHY_RST_CYCLES, go to SETTLE.
//   - SETTLE: phy_reset_n = 1. After PHY_SETTLE_CYCLES, go to RUN.
//   - RUN: ready = 1.
//   - Synced pll_locked = 0 in any state -> PHY_RST next cycle. Counter is cleared, all per-port FSMs forced to
//     STABLE, tx_clk_sel forced to 01, mac_tx_reset forced to all 1s. speed_change_cnt is kept.
//   - Outside RUN, per-port FSMs are held in STABLE and mac_tx_reset = 1.
//     mac_tx_reset drops in the first RUN cycle.
//  Per-port FSM (independent per port, active only in RUN):
//   - STABLE: if candidate != tx_clk_sel, latch the candidate, dcnt = 1, go to DEBOUNCE.
//   - DEBOUNCE:
//     - candidate == tx_clk_sel -> STABLE (glitch rejected, no reset pulse).
//     - candidate != latched value -> re-latch the new candidate, dcnt = 1.
//     - otherwise dcnt++. When dcnt = DEBOUNCE_CYCLES and the candidate still matches -> SWITCH.
//   - SWITCH:
//     - Cycle 1: mac_tx_reset = 1.
//     - Cycle 2: tx_clk_sel <= latched code; speed_change_cnt++ (saturates at 2^CNT_W-1).
//     - mac_tx_reset stays high for exactly RESET_HOLD cycles, then STABLE with mac_tx_reset = 0.
//     - Input changes during SWITCH are ignored; they are re-evaluated in STABLE.
//  Latency: input change sampled at edge 0 -> mac_tx_reset high after edge DEBOUNCE_CYCLES+2.
//  Ports never interact. Simultaneous switches on several ports are allowed.
//  Reset asserted mid-sequence returns every output to its reset value on the next edge.
// TESTING
//  Bring-up (PHY_RST_CYCLES = 10, SETTLE = 5): reset released, pll_locked = 1 -> phy_reset_n rises after 10 counted cycles
//   (after sync), ready rises 5 later; mac_tx_reset = 00 in the first RUN cycle.
//  Speed change (DEBOUNCE = 4, HOLD = 8): port0 eth_mode 0->1 steady -> mac_tx_reset[0] high 8 cycles,
//   tx_clk_sel[1:0] 01->10 one cycle after reset rise, cnt0 = 1; port1 untouched.
//  Glitch: ena_10[1] pulsed high for 3 cycles, DEBOUNCE = 4 -> no mac_tx_reset[1], sel unchanged, cnt1 = 0.
//  Re-latch: port0 goes 01->00 for 2 cycles, then ->10 steady -> single switch straight to 10, cnt0 += 1.
//  Lock loss: pll_locked drops in RUN during port0 SWITCH -> phy_reset_n = 0, ready = 0, mac_tx_reset = 11,
//   sel = 01 within 3 cycles; counters retained.
//  Saturation (CNT_W = 2): 5 accepted changes -> cnt = 3.

Source files
------------

// File: rtl/eth_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : eth_link_supervisor
// Description : Per-port link supervisor for triple-speed Ethernet channels.
//               Sequences the shared PHY reset after PLL lock, debounces each
//               MAC's reported speed and holds the MAC TX path in reset while
//               the external TX clock mux switches.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_link_supervisor #(
    parameter int NUM_PORTS         = 2,
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int RESET_HOLD        = 64,
    parameter int PHY_RST_CYCLES    = 500000,
    parameter int PHY_SETTLE_CYCLES = 50000,
    parameter int CNT_W             = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pll_locked,
    input  logic [NUM_PORTS-1:0]       eth_mode,
    input  logic [NUM_PORTS-1:0]       ena_10,
    output logic                       phy_reset_n,
    output logic                       ready,
    output logic [2*NUM_PORTS-1:0]     tx_clk_sel,
    output logic [NUM_PORTS-1:0]       mac_tx_reset,
    output logic [CNT_W*NUM_PORTS-1:0] speed_change_cnt
);

    localparam int c_GCNT_MAX = (PHY_RST_CYCLES > PHY_SETTLE_CYCLES) ? PHY_RST_CYCLES : PHY_SETTLE_CYCLES;
    localparam int c_GCNT_W   = $clog2(c_GCNT_MAX + 1);
    localparam int c_DCNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HCNT_W   = $clog2(RESET_HOLD);

    localparam logic [c_GCNT_W-1:0] c_RST_LAST    = c_GCNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [c_GCNT_W-1:0] c_SETTLE_LAST = c_GCNT_W'(PHY_SETTLE_CYCLES - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_DONE   = c_DCNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_HCNT_W-1:0] c_HOLD_LAST   = c_HCNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX     = '1;
    localparam logic [1:0]          c_SEL_2M5     = 2'b00;
    localparam logic [1:0]          c_SEL_25M     = 2'b01;
    localparam logic [1:0]          c_SEL_125M    = 2'b10;

    typedef enum logic [1:0] {
        G_PHY_RST = 2'd0,
        G_SETTLE  = 2'd1,
        G_RUN     = 2'd2
    } gstate_t;

    typedef enum logic [1:0] {
        P_STABLE   = 2'd0,
        P_DEBOUNCE = 2'd1,
        P_SWITCH   = 2'd2
    } pstate_t;

    logic                 r_pll_s1, r_pll_s2;
    logic [NUM_PORTS-1:0] r_eth_s1, r_eth_s2;
    logic [NUM_PORTS-1:0] r_ena_s1, r_ena_s2;
    gstate_t              r_gstate, w_gstate_nxt;
    logic [c_GCNT_W-1:0]  r_gcnt, w_gcnt_nxt;
    logic                 w_force;

    // Two-stage synchronisers for the asynchronous lock and speed inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pll_s1 <= 1'b0;
            r_pll_s2 <= 1'b0;
            r_eth_s1 <= '0;
            r_eth_s2 <= '0;
            r_ena_s1 <= '0;
            r_ena_s2 <= '0;
        end else begin
            r_pll_s1 <= pll_locked;
            r_pll_s2 <= r_pll_s1;
            r_eth_s1 <= eth_mode;
            r_eth_s2 <= r_eth_s1;
            r_ena_s1 <= ena_10;
            r_ena_s2 <= r_ena_s1;
        end
    end

    // Global bring-up state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gstate <= G_PHY_RST;
            r_gcnt   <= '0;
        end else begin
            r_gstate <= w_gstate_nxt;
            r_gcnt   <= w_gcnt_nxt;
        end
    end

    // Global next state: PHY reset counts only while locked, lock loss restarts it
    always_comb begin
        w_gstate_nxt = r_gstate;
        w_gcnt_nxt   = r_gcnt;
        if (!r_pll_s2) begin
            w_gstate_nxt = G_PHY_RST;
            w_gcnt_nxt   = '0;
        end else begin
            case (r_gstate)
                G_PHY_RST: begin
                    if (r_gcnt == c_RST_LAST) begin
                        w_gstate_nxt = G_SETTLE;
                        w_gcnt_nxt   = '0;
                    end else begin
                        w_gcnt_nxt = r_gcnt + c_GCNT_W'(1);
                    end
                end
                G_SETTLE: begin
                    if (r_gcnt == c_SETTLE_LAST) begin
                        w_gstate_nxt = G_RUN;
                        w_gcnt_nxt   = '0;
                    end else begin
                        w_gcnt_nxt = r_gcnt + c_GCNT_W'(1);
                    end
                end
                G_RUN: begin
                    w_gcnt_nxt = '0;
                end
                default: begin
                    w_gstate_nxt = G_PHY_RST;
                    w_gcnt_nxt   = '0;
                end
            endcase
        end
    end

    assign phy_reset_n = (r_gstate != G_PHY_RST);
    assign ready       = (r_gstate == G_RUN);
    // Ports are parked (STABLE, 25M, TX in reset) whenever the link is not running
    assign w_force     = !r_pll_s2 || (r_gstate != G_RUN);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        pstate_t             r_pstate, w_pstate_nxt;
        logic [1:0]          r_sel, w_sel_nxt;
        logic [1:0]          r_latch, w_latch_nxt;
        logic [1:0]          w_cand;
        logic [c_DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
        logic [c_HCNT_W-1:0] r_hcnt, w_hcnt_nxt;
        logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

        assign w_cand = r_eth_s2[p] ? c_SEL_125M : (r_ena_s2[p] ? c_SEL_2M5 : c_SEL_25M);

        // Per-port state register
        always_ff @(posedge clk) begin
            if (reset) begin
                r_pstate <= P_STABLE;
                r_sel    <= c_SEL_25M;
                r_latch  <= c_SEL_25M;
                r_dcnt   <= '0;
                r_hcnt   <= '0;
                r_cnt    <= '0;
            end else begin
                r_pstate <= w_pstate_nxt;
                r_sel    <= w_sel_nxt;
                r_latch  <= w_latch_nxt;
                r_dcnt   <= w_dcnt_nxt;
                r_hcnt   <= w_hcnt_nxt;
                r_cnt    <= w_cnt_nxt;
            end
        end

        // Debounce a new speed, then hold TX reset while the clock select moves
        always_comb begin
            w_pstate_nxt = r_pstate;
            w_sel_nxt    = r_sel;
            w_latch_nxt  = r_latch;
            w_dcnt_nxt   = r_dcnt;
            w_hcnt_nxt   = r_hcnt;
            w_cnt_nxt    = r_cnt;
            if (w_force) begin
                w_pstate_nxt = P_STABLE;
                w_sel_nxt    = c_SEL_25M;
            end else begin
                case (r_pstate)
                    P_STABLE: begin
                        if (w_cand != r_sel) begin
                            w_latch_nxt  = w_cand;
                            w_dcnt_nxt   = c_DCNT_W'(1);
                            w_pstate_nxt = P_DEBOUNCE;
                        end
                    end
                    P_DEBOUNCE: begin
                        if (w_cand == r_sel) begin
                            w_pstate_nxt = P_STABLE;
                        end else if (w_cand != r_latch) begin
                            w_latch_nxt = w_cand;
                            w_dcnt_nxt  = c_DCNT_W'(1);
                        end else if (r_dcnt == c_DCNT_DONE) begin
                            w_pstate_nxt = P_SWITCH;
                            w_hcnt_nxt   = '0;
                        end else begin
                            w_dcnt_nxt = r_dcnt + c_DCNT_W'(1);
                        end
                    end
                    P_SWITCH: begin
                        // Select moves one cycle after TX reset asserts
                        if (r_hcnt == '0) begin
                            w_sel_nxt = r_latch;
                            if (r_cnt != c_CNT_MAX) begin
                                w_cnt_nxt = r_cnt + CNT_W'(1);
                            end
                        end
                        if (r_hcnt == c_HOLD_LAST) begin
                            w_pstate_nxt = P_STABLE;
                            w_hcnt_nxt   = '0;
                        end else begin
                            w_hcnt_nxt = r_hcnt + c_HCNT_W'(1);
                        end
                    end
                    default: begin
                        w_pstate_nxt = P_STABLE;
                    end
                endcase
            end
        end

        assign tx_clk_sel[2*p +: 2]           = r_sel;
        assign mac_tx_reset[p]                = (r_gstate != G_RUN) || (r_pstate == P_SWITCH);
        assign speed_change_cnt[CNT_W*p +: CNT_W] = r_cnt;
    end

endmodule
`default_nettype wire
